enc_axil_result_writer: RTL
===========================

// Module: enc_axil_result_writer
// PURPOSE
//  Parametrised successor to the encryption core's data_out AXI4-Lite master.
//  - Accepts cipher words on a valid/ready stream and buffers them in a small FIFO.
//  - On INIT_AXI_TXN, writes C_NUM_WORDS words to consecutive addresses from C_BASE_ADDR.
//  - Optionally reads every word back and compares it; reports TXN_DONE and ERROR.
//  - Sits between the cipher datapath and the system interconnect.
// PARAMETERS
//  C_DATA_WIDTH  32            AXI data / stream word width (32 or 64)
//  C_ADDR_WIDTH  32            AXI address width
//  C_BASE_ADDR   32'h4000_0000 target address of word 0; aligned to C_DATA_WIDTH/8
//  C_NUM_WORDS   4             words per batch, 1..256
//  C_FIFO_DEPTH  4             input FIFO depth, power of 2, >=2
//  C_VERIFY      1             1: read back and compare after writes; 0: write only
// PORTS
//  ACLK           in   1       single clock; all logic rising-edge
//  ARESETN        in   1       asynchronous, active-low reset
//  INIT_AXI_TXN   in   1       start request; rising edge detected internally
//  s_data         in   C_DATA_WIDTH  cipher word
//  s_valid        in   1       s_data valid
//  s_ready        out  1       FIFO not full
//  TXN_DONE       out  1       batch complete, level
//  ERROR          out  1       sticky failure flag for the current batch
//  busy           out  1       FSM not in IDLE/DONE
//  word_idx       out  8       index of the word currently in flight
//  M_AXI_AW{ADDR,PROT,VALID,READY}, M_AXI_W{DATA,STRB,VALID,READY},
//  M_AXI_B{RESP,VALID,READY}, M_AXI_AR{ADDR,PROT,VALID,READY},
//  M_AXI_R{DATA,RESP,VALID,READY}  standard AXI4-Lite master; PROT=3'b000, WSTRB all ones
// BEHAVIOUR
//  - Reset (async assert, sync deassert use): every VALID/READY output, TXN_DONE, ERROR,
//    busy and word_idx are 0; FIFO is empty; FSM goes to IDLE. Mid-burst reset drops all
//    VALIDs at once; the bus is not drained.
//  - Start: init_pulse = INIT_AXI_TXN & ~init_q. Registered; the FSM leaves IDLE/DONE on the
//    cycle after the edge. Clears TXN_DONE, ERROR and word_idx. An edge while busy is ignored.
//  - FSM: IDLE -> WR_ISSUE -> WR_RESP -> (next word: WR_ISSUE | last: RD_ISSUE if C_VERIFY,
//    else DONE); RD_ISSUE -> RD_DATA -> (next: RD_ISSUE | last: DONE); DONE -> WR_ISSUE on init_pulse.
//  - WR_ISSUE: waits while the FIFO is empty, with no VALID asserted. When a word is available:
//    - pops it and drives AWVALID and WVALID together;
//    - each VALID drops independently on its own handshake;
//    - leaves for WR_RESP once both handshakes are done;
//    - stores the word into shadow[word_idx] (C_VERIFY=1 only).
//  - Transaction rules: BREADY=1 only in WR_RESP, RREADY=1 only in RD_DATA.
//    One outstanding transaction at a time. VALIDs never drop before READY.
//  - Address: C_BASE_ADDR + word_idx*(C_DATA_WIDTH/8), truncated to C_ADDR_WIDTH (wraps, no error).
//  - ERROR is set (sticky until next init_pulse) on any of:
//    - BRESP != OKAY;
//    - RRESP != OKAY;
//    - RDATA != shadow[word_idx].
//    The batch still runs to completion.
//  - DONE: TXN_DONE=1, busy=0; held until the next init_pulse.
//  - FIFO: push when s_valid & s_ready. Pop and push in the same cycle on a full FIFO is legal
//    (s_ready reflects registered full, so no push occurs when full). The FIFO keeps accepting
//    data in any state. Leftover words stay queued for the next batch.
//  - word_idx: 0..C_NUM_WORDS-1; increments after each B (write) or R (read) handshake;
//    cleared on entering RD_ISSUE.
//  - Latency: first AWVALID 2 cycles after the INIT edge when the FIFO is non-empty; with
//    zero-wait slaves, 3 cycles per write and 2 cycles per read.
// STRUCTURE
//  - enc_axil_pkg: AXI resp localparams (OKAY/EXOKAY/SLVERR/DECERR) and the state_t enum
//    {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_DATA, DONE}.
//  - Sub-module enc_word_fifo: sync FIFO (width, depth params; full/empty/push/pop), registered outputs.
//  - Shadow buffer: flat register array C_NUM_WORDS x C_DATA_WIDTH inside the top; omitted when C_VERIFY=0.
// TESTING
//  - Basic: preload 1,2,3,4; pulse INIT 20ns; OKAY memory slave -> AW addrs 0x4000_0000..0C with
//    data 1..4, reads match, TXN_DONE=1, ERROR=0.
//  - Starved FIFO: INIT with FIFO empty, feed words 100 cycles apart -> no AWVALID while empty,
//    all 4 writes complete in order, ERROR=0.
//  - Backpressure: AWREADY delayed 3 cycles, WREADY 0 cycles, then swapped -> VALIDs held stable,
//    exactly one B per write, data unchanged.
//  - Errors: SLVERR on write 2 -> ERROR=1, batch still finishes. Separate run: slave corrupts
//    word 3 on read -> ERROR=1. Next INIT clears ERROR.
//  - Modes: C_VERIFY=0, C_NUM_WORDS=1 -> no AR traffic, TXN_DONE after one B.
//    C_DATA_WIDTH=64 -> address stride 8.
//  - Reset mid-op: deassert ARESETN during WR_RESP of word 2 -> all VALIDs and TXN_DONE 0
//    immediately, FIFO empty. Re-run of the basic test passes.

Source files
------------

// File: rtl/enc_axil_result_writer_pkg.sv
// Shared AXI4-Lite response codes and FSM state encoding for the result writer.
package enc_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_DATA,
        DONE
    } state_t;

endpackage

// File: rtl/enc_axil_result_writer_if.sv
// AXI4-Lite bus bundle between the result writer (master) and the interconnect (slave).
// Handshake: a transfer happens on a rising edge where VALID and READY are both high;
// once VALID is raised it and its payload stay stable until that edge.
interface enc_axil_result_writer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/enc_axil_result_writer_fifo.sv
// Small synchronous FIFO for incoming cipher words; full/empty are registered flags.
module enc_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_next;
    logic             do_push, do_pop;

    // Push is gated by the registered full flag, so push+pop on a full FIFO only pops.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (PTR_W+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/enc_axil_result_writer.sv
// AXI4-Lite master that writes a batch of buffered cipher words to consecutive
// addresses, optionally reads them back, and flags any bad response or mismatch.
module enc_axil_result_writer
    import enc_axil_pkg::*;
#(
    parameter int                      C_DATA_WIDTH = 32,
    parameter int                      C_ADDR_WIDTH = 32,
    parameter logic [C_ADDR_WIDTH-1:0] C_BASE_ADDR  = 32'h4000_0000,
    parameter int                      C_NUM_WORDS  = 4,
    parameter int                      C_FIFO_DEPTH = 4,
    parameter int                      C_VERIFY     = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    INIT_AXI_TXN,
    input  logic [C_DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic                    TXN_DONE,
    output logic                    ERROR,
    output logic                    busy,
    output logic [7:0]              word_idx,
    output state_t                  fsm_state,
    enc_axil_result_writer_if.master m_axi
);

    localparam int BYTES = C_DATA_WIDTH / 8;

    state_t                  state, state_next;
    logic                    init_q, init_pulse_r, start;
    logic                    awvalid_q, wvalid_q, arvalid_q, issued, error_q;
    logic                    bready_c, rready_c;
    logic [C_DATA_WIDTH-1:0] wdata_q, fifo_data;
    logic                    fifo_full, fifo_empty, pop, last, rd_mismatch;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [C_ADDR_WIDTH-1:0] addr;

    enc_word_fifo #(.WIDTH(C_DATA_WIDTH), .DEPTH(C_FIFO_DEPTH)) u_fifo (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .push     (s_valid),
        .push_data(s_data),
        .pop      (pop),
        .pop_data (fifo_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign s_ready = ~fifo_full;
    assign pop     = (state == WR_ISSUE) && !issued && !fifo_empty;
    assign start   = init_pulse_r && ((state == IDLE) || (state == DONE));
    assign last    = (word_idx == 8'(C_NUM_WORDS - 1));
    // Address wraps silently at C_ADDR_WIDTH.
    assign addr    = C_BASE_ADDR + C_ADDR_WIDTH'(word_idx) * C_ADDR_WIDTH'(BYTES);

    assign aw_hs = awvalid_q && m_axi.awready;
    assign w_hs  = wvalid_q && m_axi.wready;
    assign b_hs  = bready_c && m_axi.bvalid;
    assign ar_hs = arvalid_q && m_axi.arready;
    assign r_hs  = rready_c && m_axi.rvalid;

    generate
        if (C_VERIFY != 0) begin : g_shadow
            localparam int IDX_W = (C_NUM_WORDS > 1) ? $clog2(C_NUM_WORDS) : 1;
            logic [C_DATA_WIDTH-1:0] shadow [C_NUM_WORDS];
            logic [IDX_W-1:0]        sidx;
            assign sidx = word_idx[IDX_W-1:0];
            always_ff @(posedge ACLK) begin
                if (pop) shadow[sidx] <= fifo_data;
            end
            assign rd_mismatch = (m_axi.rdata != shadow[sidx]);
        end else begin : g_no_shadow
            assign rd_mismatch = 1'b0;
        end
    endgenerate

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (init_pulse_r) state_next = WR_ISSUE;
            WR_ISSUE:   if (issued && (!awvalid_q || aw_hs) && (!wvalid_q || w_hs))
                            state_next = WR_RESP;
            WR_RESP:    if (b_hs) state_next = !last ? WR_ISSUE :
                                               (C_VERIFY != 0) ? RD_ISSUE : DONE;
            RD_ISSUE:   if (ar_hs) state_next = RD_DATA;
            RD_DATA:    if (r_hs) state_next = last ? DONE : RD_ISSUE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        bready_c  = (state == WR_RESP);
        rready_c  = (state == RD_DATA);
        busy      = (state != IDLE) && (state != DONE);
        TXN_DONE  = (state == DONE);
        fsm_state = state;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            init_q       <= 1'b0;
            init_pulse_r <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            issued       <= 1'b0;
            error_q      <= 1'b0;
            wdata_q      <= '0;
            word_idx     <= '0;
        end else begin
            init_q       <= INIT_AXI_TXN;
            init_pulse_r <= INIT_AXI_TXN & ~init_q;
            if (start) begin
                word_idx <= '0;
                error_q  <= 1'b0;
            end
            if (pop) begin
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                wdata_q   <= fifo_data;
                issued    <= 1'b1;
            end
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if ((state == WR_ISSUE) && (state_next == WR_RESP)) issued <= 1'b0;
            if (b_hs) begin
                if (m_axi.bresp != RESP_OKAY) error_q <= 1'b1;
                if (!last)                word_idx <= word_idx + 1'b1;
                else if (C_VERIFY != 0)   word_idx <= '0;
            end
            // ARVALID is raised on entry so a zero-wait slave completes a read in two cycles.
            if ((state_next == RD_ISSUE) && (state != RD_ISSUE)) arvalid_q <= 1'b1;
            else if (ar_hs)                                     arvalid_q <= 1'b0;
            if (r_hs) begin
                if ((m_axi.rresp != RESP_OKAY) || rd_mismatch) error_q <= 1'b1;
                if (!last) word_idx <= word_idx + 1'b1;
            end
        end
    end

    assign ERROR = error_q;

    assign m_axi.awaddr  = addr;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = '1;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_c;
    assign m_axi.araddr  = addr;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_c;

endmodule
